gb_hram_intc_responder: RTL and testbench

//  Bus responder on the CPU address/data bus for the core-internal memory map:

---
 rtl/gb_hram_intc_responder_if.sv | 24 ++
 rtl/gb_hram_intc_responder.sv | 127 ++++++++++++
 tb/tb_gb_hram_intc_responder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/gb_hram_intc_responder_if.sv
// CPU address/data bus bundle between the core and the HRAM/IF/IE responder.
interface gb_hram_intc_responder_if;
  logic [15:0] addr_bus;
  logic [7:0]  data_bus_o;
  logic        drive_data_bus;
  logic [7:0]  data_bus_i;
  logic        rd_hit;

  modport master (
    output addr_bus,
    output data_bus_o,
    output drive_data_bus,
    input  data_bus_i,
    input  rd_hit
  );

  modport slave (
    input  addr_bus,
    input  data_bus_o,
    input  drive_data_bus,
    output data_bus_i,
    output rd_hit
  );
endinterface

// File: rtl/gb_hram_intc_responder.sv
// HRAM, IF and IE responder on the CPU bus, plus interrupt
// priority encoding and dispatch-acknowledge handling.
module gb_hram_intc_responder #(
  parameter logic [15:0] HRAM_BASE  = 16'hFF80,
  parameter int          HRAM_DEPTH = 127,
  parameter logic [15:0] IF_ADDR    = 16'hFF0F,
  parameter logic [15:0] IE_ADDR    = 16'hFFFF
) (
  input  logic                      clk,
  input  logic                      reset,
  gb_hram_intc_responder_if.slave   bus,
  input  logic [4:0]                irq_req,
  output logic                      irq_pending,
  output logic [7:0]                irq_vector,
  input  logic                      irq_ack,
  output logic [7:0]                irq_ack_vector
);

  localparam int AW = $clog2(HRAM_DEPTH);
  localparam logic [15:0] HRAM_END = 16'(HRAM_BASE + HRAM_DEPTH);

  logic [7:0]    hram_q [HRAM_DEPTH];
  logic [4:0]    if_q, if_d;
  logic [7:0]    ie_q, ie_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          hit_q, hit_d;
  logic [7:0]    ackv_q, ackv_d;

  logic          hram_hit, if_hit, ie_hit;
  logic          wr, hram_we;
  logic [AW-1:0] ofs;
  logic [4:0]    pend, low;

  assign hram_hit = (bus.addr_bus >= HRAM_BASE) &&
                    (bus.addr_bus < HRAM_END);
  assign if_hit   = bus.addr_bus == IF_ADDR;
  assign ie_hit   = bus.addr_bus == IE_ADDR;
  assign wr       = bus.drive_data_bus;
  assign hram_we  = wr && hram_hit;
  assign ofs      = AW'(bus.addr_bus - HRAM_BASE);

  // Isolate the lowest pending bit; vblank (bit 0) wins.
  assign pend = ie_q[4:0] & if_q;
  assign low  = pend & (~pend + 5'd1);

  always_comb begin
    irq_vector = 8'h00;
    unique case (1'b1)
      low[0]:  irq_vector = 8'h40;
      low[1]:  irq_vector = 8'h48;
      low[2]:  irq_vector = 8'h50;
      low[3]:  irq_vector = 8'h58;
      low[4]:  irq_vector = 8'h60;
      default: irq_vector = 8'h00;
    endcase
  end

  assign irq_pending = |pend;

  always_comb begin
    if_d    = if_q;
    ie_d    = ie_q;
    ackv_d  = ackv_q;
    rdata_d = 8'hFF;
    hit_d   = 1'b0;
    if (wr && if_hit) begin
      if_d = bus.data_bus_o[4:0];
    end else if (irq_ack) begin
      if_d = if_q & ~low;
    end
    // Requests are ORed last so a same-cycle request survives.
    if_d = if_d | irq_req;
    if (wr && ie_hit) begin
      ie_d = bus.data_bus_o;
    end
    if (irq_ack) begin
      ackv_d = irq_vector;
    end
    if (!wr) begin
      unique case (1'b1)
        hram_hit: begin
          rdata_d = hram_q[ofs];
          hit_d   = 1'b1;
        end
        if_hit: begin
          rdata_d = {3'b111, if_q};
          hit_d   = 1'b1;
        end
        ie_hit: begin
          rdata_d = ie_q;
          hit_d   = 1'b1;
        end
        default: begin
          rdata_d = 8'hFF;
          hit_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_q    <= 5'h00;
      ie_q    <= 8'h00;
      rdata_q <= 8'hFF;
      hit_q   <= 1'b0;
      ackv_q  <= 8'h00;
    end else begin
      if_q    <= if_d;
      ie_q    <= ie_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      ackv_q  <= ackv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && hram_we) begin
      hram_q[ofs] <= bus.data_bus_o;
    end
  end

  assign bus.data_bus_i = rdata_q;
  assign bus.rd_hit     = hit_q;
  assign irq_ack_vector = ackv_q;

endmodule

// File: tb/tb_gb_hram_intc_responder.sv
// Vector-table bench for the HRAM/IF/IE responder with a
// scoreboard queue of expected post-edge outputs.
module tb_gb_hram_intc_responder;

  typedef struct {
    logic        rst;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [4:0]  req;
    logic        ack;
    logic [7:0]  e_data;
    logic        e_hit;
    logic        e_pend;
    logic [7:0]  e_vec;
    logic [7:0]  e_ackv;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [4:0] irq_req;
  logic       irq_pending;
  logic [7:0] irq_vector;
  logic       irq_ack;
  logic [7:0] irq_ack_vector;

  int checks;
  int errors;

  vec_t tbl[$];
  vec_t sb[$];

  gb_hram_intc_responder_if bus ();

  gb_hram_intc_responder dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .irq_req        (irq_req),
    .irq_pending    (irq_pending),
    .irq_vector     (irq_vector),
    .irq_ack        (irq_ack),
    .irq_ack_vector (irq_ack_vector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rst, input logic we,
    input logic [15:0] addr, input logic [7:0] wd,
    input logic [4:0] req, input logic ack,
    input logic [7:0] e_data, input logic e_hit,
    input logic e_pend, input logic [7:0] e_vec,
    input logic [7:0] e_ackv);
    vec_t v;
    v.rst = rst; v.we = we; v.addr = addr; v.wd = wd;
    v.req = req; v.ack = ack; v.e_data = e_data;
    v.e_hit = e_hit; v.e_pend = e_pend;
    v.e_vec = e_vec; v.e_ackv = e_ackv;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    reset              = v.rst;
    bus.drive_data_bus = v.we;
    bus.addr_bus       = v.addr;
    bus.data_bus_o     = v.wd;
    irq_req            = v.req;
    irq_ack            = v.ack;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard step %0d: empty queue", idx);
    end else begin
      e = sb.pop_front();
      chk("data_bus_i", idx, bus.data_bus_i, e.e_data);
      chk("rd_hit", idx, {7'd0, bus.rd_hit}, {7'd0, e.e_hit});
      chk("irq_pending", idx, {7'd0, irq_pending}, {7'd0, e.e_pend});
      chk("irq_vector", idx, irq_vector, e.e_vec);
      chk("irq_ack_vector", idx, irq_ack_vector, e.e_ackv);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.drive_data_bus = 1'b0;
    bus.addr_bus = 16'h0000;
    bus.data_bus_o = 8'h00;
    irq_req = 5'h00;
    irq_ack = 1'b0;

    // rst we addr wd req ack | data hit pend vec ackv
    tbl.push_back(mk(1,0,16'h0000,8'h00,5'h00,0, 8'hFF,0,0,8'h00,8'h00));
    tbl.push_back(mk(0,1,16'hFF80,8'hA5,5'h00,0, 8'hFF,0,0,8'h00,8'h00));
    tbl.push_back(mk(0,1,16'hFFFE,8'h3C,5'h00,0, 8'hFF,0,0,8'h00,8'h00));
    tbl.push_back(mk(0,0,16'hFF80,8'h00,5'h00,0, 8'hA5,1,0,8'h00,8'h00));
    tbl.push_back(mk(0,0,16'hFFFE,8'h00,5'h00,0, 8'h3C,1,0,8'h00,8'h00));
    tbl.push_back(mk(0,0,16'hC000,8'h00,5'h00,0, 8'hFF,0,0,8'h00,8'h00));
    tbl.push_back(mk(0,1,16'hFF0F,8'hFF,5'h00,0, 8'hFF,0,0,8'h00,8'h00));
    tbl.push_back(mk(0,0,16'hFF0F,8'h00,5'h00,0, 8'hFF,1,0,8'h00,8'h00));
    tbl.push_back(mk(0,1,16'hFF0F,8'h00,5'h00,0, 8'hFF,0,0,8'h00,8'h00));
    tbl.push_back(mk(0,1,16'hFFFF,8'h1F,5'h00,0, 8'hFF,0,0,8'h00,8'h00));
    tbl.push_back(mk(0,0,16'hC000,8'h00,5'h14,0, 8'hFF,0,1,8'h50,8'h00));
    tbl.push_back(mk(0,0,16'hFFFF,8'h00,5'h00,0, 8'h1F,1,1,8'h50,8'h00));
    tbl.push_back(mk(0,0,16'hC000,8'h00,5'h00,1, 8'hFF,0,1,8'h60,8'h50));
    tbl.push_back(mk(0,0,16'hFF0F,8'h00,5'h00,0, 8'hF0,1,1,8'h60,8'h50));
    tbl.push_back(mk(0,0,16'hC000,8'h00,5'h00,1, 8'hFF,0,0,8'h00,8'h60));
    tbl.push_back(mk(0,1,16'hFFFF,8'h00,5'h00,0, 8'hFF,0,0,8'h00,8'h60));
    tbl.push_back(mk(0,0,16'hC000,8'h00,5'h01,0, 8'hFF,0,0,8'h00,8'h60));
    tbl.push_back(mk(0,0,16'hC000,8'h00,5'h00,1, 8'hFF,0,0,8'h00,8'h00));
    tbl.push_back(mk(0,0,16'hFF0F,8'h00,5'h00,0, 8'hE1,1,0,8'h00,8'h00));
    tbl.push_back(mk(0,1,16'hFF0F,8'h04,5'h00,0, 8'hFF,0,0,8'h00,8'h00));
    tbl.push_back(mk(0,1,16'hFFFF,8'h04,5'h00,0, 8'hFF,0,1,8'h50,8'h00));
    tbl.push_back(mk(0,0,16'hC000,8'h00,5'h04,1, 8'hFF,0,1,8'h50,8'h50));
    tbl.push_back(mk(0,0,16'hFF0F,8'h00,5'h00,0, 8'hE4,1,1,8'h50,8'h50));
    tbl.push_back(mk(0,1,16'hFF0F,8'h00,5'h02,0, 8'hFF,0,0,8'h00,8'h50));
    tbl.push_back(mk(0,0,16'hFF0F,8'h00,5'h00,0, 8'hE2,1,0,8'h00,8'h50));
    tbl.push_back(mk(1,1,16'hFFFF,8'h77,5'h00,0, 8'hFF,0,0,8'h00,8'h00));
    tbl.push_back(mk(0,0,16'hFFFF,8'h00,5'h00,0, 8'h00,1,0,8'h00,8'h00));
    tbl.push_back(mk(0,0,16'hFF0F,8'h00,5'h00,0, 8'hE0,1,0,8'h00,8'h00));
    tbl.push_back(mk(0,0,16'hFF7F,8'h00,5'h00,0, 8'hFF,0,0,8'h00,8'h00));
    tbl.push_back(mk(0,0,16'hFF80,8'h00,5'h00,0, 8'hA5,1,0,8'h00,8'h00));
    tbl.push_back(mk(0,1,16'hC000,8'h12,5'h00,0, 8'hFF,0,0,8'h00,8'h00));
    tbl.push_back(mk(0,0,16'hFF80,8'h00,5'h00,0, 8'hA5,1,0,8'h00,8'h00));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // Held vblank request re-arms IF across back-to-back acks.
    apply(mk(0,1,16'hFFFF,8'h01,5'h00,0, 8'hFF,0,0,8'h00,8'h00), 100);
    apply(mk(0,0,16'hC000,8'h00,5'h01,0, 8'hFF,0,1,8'h40,8'h00), 101);
    apply(mk(0,0,16'hC000,8'h00,5'h01,1, 8'hFF,0,1,8'h40,8'h40), 102);
    apply(mk(0,0,16'hC000,8'h00,5'h01,1, 8'hFF,0,1,8'h40,8'h40), 103);
    // HRAM write immediately followed by a read of the same byte.
    apply(mk(0,1,16'hFFC0,8'h5A,5'h00,0, 8'hFF,0,1,8'h40,8'h40), 104);
    apply(mk(0,0,16'hFFC0,8'h00,5'h00,0, 8'h5A,1,1,8'h40,8'h40), 105);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
